// File: rtl/conv_pkg.sv
// Shared types and constants for the 1-D convolution controller slice.
package conv_pkg;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_CLEAR = 2'd1,
    S_MAC   = 2'd2,
    S_OUT   = 2'd3
  } conv_state_t;

  localparam int DATA_W       = 8;
  localparam int PROD_W       = 16;
  localparam int ACC_W        = 18;
  localparam int DATA_N_DEF   = 8;
  localparam int FILTER_N_DEF = 4;

  // Number of valid-mode outputs per frame.
  function automatic int n_out(input int data_n, input int filter_n);
    return data_n - filter_n + 1;
  endfunction

  localparam int N_OUT = n_out(DATA_N_DEF, FILTER_N_DEF);

endpackage

// File: rtl/conv_controller_if.sv
// Handshake and memory/accumulator control bundle between the controller and its datapath.
interface conv_controller_if #(
  parameter int LG_DATA_N   = 3,
  parameter int LG_FILTER_N = 2
);
  logic                   s_valid_x;
  logic                   s_ready_x;
  logic                   s_valid_f;
  logic                   s_ready_f;
  logic [LG_DATA_N-1:0]   addr_x;
  logic                   wr_en_x;
  logic [LG_FILTER_N-1:0] addr_f;
  logic                   wr_en_f;
  logic                   clear_acc;
  logic                   en_acc;
  logic                   m_valid_y;
  logic                   m_ready_y;

  modport master (
    input  s_valid_x, s_valid_f, m_ready_y,
    output s_ready_x, s_ready_f, addr_x, wr_en_x, addr_f, wr_en_f,
           clear_acc, en_acc, m_valid_y
  );

  modport slave (
    output s_valid_x, s_valid_f, m_ready_y,
    input  s_ready_x, s_ready_f, addr_x, wr_en_x, addr_f, wr_en_f,
           clear_acc, en_acc, m_valid_y
  );
endinterface

// File: rtl/conv_idx_counter.sv
// Index counter with synchronous clear, increment and a compare-to-limit flag.
module conv_idx_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);
  logic [WIDTH-1:0] count_r;

  // Count register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count    = count_r;
  assign at_limit = (count_r == WIDTH'(LIMIT));
endmodule

// File: rtl/conv_controller.sv
// Sequencer for the 1-D valid-mode convolution datapath: load x/f, MAC each y[n], hand it off.
// Optional macro CONV_PERF_CNT_EN adds the busy_cycles performance counter output.
module conv_controller
  import conv_pkg::*;
#(
  parameter int DATA_N      = 8,
  parameter int FILTER_N    = 4,
  parameter int LG_DATA_N   = 3,
  parameter int LG_FILTER_N = 2
) (
  input  logic clk,
  input  logic reset,
  conv_controller_if.master bus
`ifdef CONV_PERF_CNT_EN
  ,
  output logic [15:0] busy_cycles
`endif
);
  localparam int CX_W    = LG_DATA_N + 1;
  localparam int CF_W    = LG_FILTER_N + 1;
  localparam int OUT_CNT = n_out(DATA_N, FILTER_N);

  conv_state_t state_r;
  conv_state_t state_next_s;

  logic [CX_W-1:0]        cnt_x_s;
  logic [CF_W-1:0]        cnt_f_s;
  logic [LG_DATA_N-1:0]   n_s;
  logic [LG_FILTER_N-1:0] j_s;
  logic                   x_full_s;
  logic                   f_full_s;
  logic                   n_last_s;
  logic                   j_last_s;

  logic inc_x_s;
  logic inc_f_s;
  logic inc_n_s;
  logic inc_j_s;
  logic clr_frame_s;
  logic clr_j_s;
  logic x_done_s;
  logic f_done_s;

  logic                   ready_x_s;
  logic                   ready_f_s;
  logic                   wr_x_s;
  logic                   wr_f_s;
  logic                   clear_s;
  logic                   en_s;
  logic                   valid_y_s;
  logic [LG_DATA_N-1:0]   addr_x_s;
  logic [LG_FILTER_N-1:0] addr_f_s;
  logic [LG_DATA_N-1:0]   mac_addr_s;

  conv_idx_counter #(.WIDTH(CX_W), .LIMIT(DATA_N)) u_cnt_x (
    .clk(clk), .reset(reset), .clr(clr_frame_s), .inc(inc_x_s),
    .count(cnt_x_s), .at_limit(x_full_s)
  );

  conv_idx_counter #(.WIDTH(CF_W), .LIMIT(FILTER_N)) u_cnt_f (
    .clk(clk), .reset(reset), .clr(clr_frame_s), .inc(inc_f_s),
    .count(cnt_f_s), .at_limit(f_full_s)
  );

  conv_idx_counter #(.WIDTH(LG_DATA_N), .LIMIT(OUT_CNT - 1)) u_cnt_n (
    .clk(clk), .reset(reset), .clr(clr_frame_s), .inc(inc_n_s),
    .count(n_s), .at_limit(n_last_s)
  );

  conv_idx_counter #(.WIDTH(LG_FILTER_N), .LIMIT(FILTER_N - 1)) u_cnt_j (
    .clk(clk), .reset(reset), .clr(clr_j_s), .inc(inc_j_s),
    .count(j_s), .at_limit(j_last_s)
  );

  // Valid-mode window never exceeds DATA_N-1, so no wrap handling is needed.
  assign mac_addr_s = n_s + LG_DATA_N'(j_s);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, counter control and output decode.
  always_comb begin
    state_next_s = state_r;
    ready_x_s    = 1'b0;
    ready_f_s    = 1'b0;
    wr_x_s       = 1'b0;
    wr_f_s       = 1'b0;
    clear_s      = 1'b0;
    en_s         = 1'b0;
    valid_y_s    = 1'b0;
    addr_x_s     = '0;
    addr_f_s     = '0;
    inc_x_s      = 1'b0;
    inc_f_s      = 1'b0;
    inc_n_s      = 1'b0;
    inc_j_s      = 1'b0;
    clr_frame_s  = 1'b0;
    clr_j_s      = 1'b0;
    x_done_s     = 1'b0;
    f_done_s     = 1'b0;
    case (state_r)
      S_LOAD: begin
        ready_x_s = !x_full_s;
        ready_f_s = !f_full_s;
        wr_x_s    = bus.s_valid_x & ready_x_s;
        wr_f_s    = bus.s_valid_f & ready_f_s;
        addr_x_s  = cnt_x_s[LG_DATA_N-1:0];
        addr_f_s  = cnt_f_s[LG_FILTER_N-1:0];
        inc_x_s   = wr_x_s;
        inc_f_s   = wr_f_s;
        // Look ahead at the write completing each memory so compute starts with no idle cycle.
        x_done_s  = x_full_s | (wr_x_s & (cnt_x_s == CX_W'(DATA_N - 1)));
        f_done_s  = f_full_s | (wr_f_s & (cnt_f_s == CF_W'(FILTER_N - 1)));
        if (x_done_s & f_done_s) begin
          state_next_s = S_CLEAR;
        end else begin
          state_next_s = S_LOAD;
        end
      end
      S_CLEAR: begin
        clear_s      = 1'b1;
        clr_j_s      = 1'b1;
        addr_x_s     = mac_addr_s;
        state_next_s = S_MAC;
      end
      S_MAC: begin
        en_s     = 1'b1;
        addr_x_s = mac_addr_s;
        addr_f_s = j_s;
        if (j_last_s) begin
          clr_j_s      = 1'b1;
          state_next_s = S_OUT;
        end else begin
          inc_j_s      = 1'b1;
          state_next_s = S_MAC;
        end
      end
      S_OUT: begin
        valid_y_s = 1'b1;
        addr_x_s  = mac_addr_s;
        if (bus.m_ready_y) begin
          if (n_last_s) begin
            clr_frame_s  = 1'b1;
            state_next_s = S_LOAD;
          end else begin
            inc_n_s      = 1'b1;
            state_next_s = S_CLEAR;
          end
        end else begin
          state_next_s = S_OUT;
        end
      end
      default: begin
        state_next_s = S_LOAD;
      end
    endcase
  end

  // Every output is forced low while reset is held.
  assign bus.s_ready_x = reset & ready_x_s;
  assign bus.s_ready_f = reset & ready_f_s;
  assign bus.wr_en_x   = reset & wr_x_s;
  assign bus.wr_en_f   = reset & wr_f_s;
  assign bus.clear_acc = reset & clear_s;
  assign bus.en_acc    = reset & en_s;
  assign bus.m_valid_y = reset & valid_y_s;
  assign bus.addr_x    = reset ? addr_x_s : '0;
  assign bus.addr_f    = reset ? addr_f_s : '0;

`ifdef CONV_PERF_CNT_EN
  logic [15:0] busy_r;

  // Busy-cycle counter: the finished frame's total stays visible through S_LOAD and is zeroed as the next frame starts computing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_r <= 16'h0000;
    end else if (state_r == S_LOAD) begin
      if (state_next_s == S_CLEAR) begin
        busy_r <= 16'h0000;
      end else begin
        busy_r <= busy_r;
      end
    end else if (busy_r != 16'hFFFF) begin
      busy_r <= busy_r + 16'h0001;
    end else begin
      busy_r <= busy_r;
    end
  end

  assign busy_cycles = reset ? busy_r : 16'h0000;
`endif

endmodule

// File: tb/tb_conv_controller.sv
// Self-checking bench for conv_controller: table of frames, randomised handshakes, reference convolution.
module tb_conv_controller;
  import conv_pkg::*;

  localparam int DATA_N       = DATA_N_DEF;
  localparam int FILTER_N     = FILTER_N_DEF;
  localparam int NV           = 7;
  localparam int FRAME_BUDGET = 2000;

  typedef struct packed {
    logic [DATA_N-1:0][7:0]    x;
    logic [FILTER_N-1:0][7:0]  f;
    logic [N_OUT-1:0][17:0]    y;
    logic [7:0]                valid_pct;
    logic                      f_first;
    logic [1:0]                rdy_mode;
    logic                      abort_en;
    logic [3:0]                abort_k;
  } frame_vec_t;

  logic clk;
  logic reset;
  logic signed [DATA_W-1:0] data_x;
  logic signed [DATA_W-1:0] data_f;
  logic signed [DATA_W-1:0] mem_x [DATA_N];
  logic signed [DATA_W-1:0] mem_f [FILTER_N];
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
`ifdef CONV_PERF_CNT_EN
  logic [15:0] busy_cycles;
`endif

  int total;
  int bad;
  frame_vec_t vecs [NV];

  conv_controller_if #(.LG_DATA_N(3), .LG_FILTER_N(2)) bus ();

  conv_controller #(
    .DATA_N(DATA_N), .FILTER_N(FILTER_N), .LG_DATA_N(3), .LG_FILTER_N(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef CONV_PERF_CNT_EN
    ,
    .busy_cycles(busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: memories written at the edge, combinational read, registered accumulator.
  always_comb prod = mem_x[bus.addr_x] * mem_f[bus.addr_f];

  always @(posedge clk) begin
    if (bus.wr_en_x) mem_x[bus.addr_x] <= data_x;
    if (bus.wr_en_f) mem_f[bus.addr_f] <= data_f;
    if (bus.clear_acc) acc <= '0;
    else if (bus.en_acc) acc <= acc + 18'(prod);
  end

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic frame_vec_t ref_model(input frame_vec_t v);
    int s;
    for (int n = 0; n < N_OUT; n++) begin
      s = 0;
      for (int j = 0; j < FILTER_N; j++) s += int'($signed(v.x[n+j])) * int'($signed(v.f[j]));
      v.y[n] = 18'(s);
    end
    return v;
  endfunction

  function automatic frame_vec_t rand_frame(input int pct, input int mode, input bit ffirst);
    frame_vec_t v;
    v = '0;
    for (int i = 0; i < DATA_N; i++) v.x[i] = 8'($urandom);
    for (int j = 0; j < FILTER_N; j++) v.f[j] = 8'($urandom);
    v.valid_pct = 8'(pct);
    v.rdy_mode  = 2'(mode);
    v.f_first   = ffirst;
    return ref_model(v);
  endfunction

  task automatic hold_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      reset = 1'b0;
      bus.s_valid_x = 1'b1;
      bus.s_valid_f = 1'b1;
      bus.m_ready_y = 1'b1;
      #1;
      chk("reset_outs", 32'({bus.s_ready_x, bus.s_ready_f, bus.addr_x, bus.wr_en_x, bus.addr_f,
                             bus.wr_en_f, bus.clear_acc, bus.en_acc, bus.m_valid_y}), 0);
`ifdef CONV_PERF_CNT_EN
      chk("reset_busy", 32'(busy_cycles), 0);
`endif
    end
    @(negedge clk);
    reset = 1'b1;
    bus.s_valid_x = 1'b0;
    bus.s_valid_f = 1'b0;
    bus.m_ready_y = 1'b0;
  endtask

  // Drives one frame cycle by cycle and checks every control output against frame-level expectations.
  task automatic run_frame(input frame_vec_t v, output bit aborted, output int busy);
    int xi, fi, k, cyc, exp_clear, exp_valid, stall_left;
    bit loading, done, exp_rx, exp_rf, exp_wx, exp_wf, exp_en, exp_vy;
    xi = 0; fi = 0; k = 0; cyc = 0; exp_clear = -1; exp_valid = -1; stall_left = 10;
    done = 1'b0; aborted = 1'b0; busy = 0;
    while (!done && cyc < FRAME_BUDGET) begin
      @(negedge clk);
      if (v.f_first && fi < FILTER_N) bus.s_valid_x = 1'b0;
      else bus.s_valid_x = ($urandom_range(0, 99) < 32'(v.valid_pct));
      bus.s_valid_f = ($urandom_range(0, 99) < 32'(v.valid_pct));
      if (xi < DATA_N) data_x = v.x[xi]; else data_x = 8'($urandom);
      if (fi < FILTER_N) data_f = v.f[fi]; else data_f = 8'($urandom);
      case (v.rdy_mode)
        2'd0:    bus.m_ready_y = 1'b1;
        2'd1:    bus.m_ready_y = 1'($urandom_range(0, 1));
        default: bus.m_ready_y = !(k == 2 && stall_left > 0);
      endcase
      #1;
      loading = (xi < DATA_N) || (fi < FILTER_N);
      exp_rx  = loading && (xi < DATA_N);
      exp_rf  = loading && (fi < FILTER_N);
      exp_wx  = exp_rx && bus.s_valid_x;
      exp_wf  = exp_rf && bus.s_valid_f;
      exp_en  = (exp_valid >= 0) && (cyc > exp_clear) && (cyc < exp_valid);
      exp_vy  = (exp_valid >= 0) && (cyc >= exp_valid);
      chk("s_ready_x", 32'(bus.s_ready_x), 32'(exp_rx));
      chk("s_ready_f", 32'(bus.s_ready_f), 32'(exp_rf));
      chk("wr_en_x", 32'(bus.wr_en_x), 32'(exp_wx));
      chk("wr_en_f", 32'(bus.wr_en_f), 32'(exp_wf));
      if (exp_wx) chk("addr_x_load", 32'(bus.addr_x), xi);
      if (exp_wf) chk("addr_f_load", 32'(bus.addr_f), fi);
      chk("clear_acc", 32'(bus.clear_acc), 32'(cyc == exp_clear));
      chk("en_acc", 32'(bus.en_acc), 32'(exp_en));
      chk("m_valid_y", 32'(bus.m_valid_y), 32'(exp_vy));
      if (exp_clear >= 0 && cyc >= exp_clear) busy++;
      if (v.abort_en && k == int'(v.abort_k) && exp_en) begin
        aborted = 1'b1;
        done = 1'b1;
      end else if (exp_vy) begin
        chk("y_value", 32'(acc), 32'($signed(v.y[k])));
        if (bus.m_ready_y) begin
          k++;
          exp_valid = -1;
          if (k == N_OUT) begin
            done = 1'b1;
          end else begin
            exp_clear = cyc + 1;
            exp_valid = exp_clear + FILTER_N + 1;
          end
        end else if (k == 2) begin
          stall_left--;
        end
      end
      if (exp_wx) xi++;
      if (exp_wf) fi++;
      if (loading && xi == DATA_N && fi == FILTER_N) begin
        exp_clear = cyc + 1;
        exp_valid = exp_clear + FILTER_N + 1;
      end
      cyc++;
    end
    if (!done) chk("frame_done", 0, 1);
  endtask

  initial begin
    int y1 [N_OUT];
    bit aborted;
    int busy;
    y1 = '{10, 14, 18, 22, 26};
    total = 0;
    bad = 0;
    reset = 1'b0;
    bus.s_valid_x = 1'b0;
    bus.s_valid_f = 1'b0;
    bus.m_ready_y = 1'b0;
    data_x = '0;
    data_f = '0;

    // Frame table: spec frames with constant expectations, then random frames scored by ref_model.
    for (int i = 0; i < NV; i++) vecs[i] = '0;
    for (int i = 0; i < DATA_N; i++) vecs[0].x[i] = 8'(i + 1);
    for (int j = 0; j < FILTER_N; j++) vecs[0].f[j] = 8'd1;
    for (int n = 0; n < N_OUT; n++) vecs[0].y[n] = 18'(y1[n]);
    vecs[0].valid_pct = 8'd100;
    vecs[1] = vecs[0];
    vecs[1].f[0] = 8'h01;
    vecs[1].f[1] = 8'hFF;
    vecs[1].f[2] = 8'h00;
    vecs[1].f[3] = 8'h00;
    for (int n = 0; n < N_OUT; n++) vecs[1].y[n] = 18'h3FFFF;
    vecs[2] = rand_frame(50, 0, 1'b1);
    vecs[3] = rand_frame(100, 2, 1'b0);
    vecs[4] = vecs[0];
    vecs[4].abort_en = 1'b1;
    vecs[4].abort_k  = 4'd1;
    vecs[5] = rand_frame(70, 1, 1'b0);
    vecs[6] = rand_frame(60, 1, 1'b0);

    hold_reset(3);
    #1;
    chk("post_reset_ready", 32'({bus.s_ready_x, bus.s_ready_f}), 3);
    chk("post_reset_idle", 32'({bus.wr_en_x, bus.wr_en_f, bus.clear_acc, bus.en_acc, bus.m_valid_y}), 0);

    for (int i = 0; i < NV; i++) begin
      run_frame(vecs[i], aborted, busy);
      if (aborted) begin
        hold_reset(3);
      end else begin
        @(negedge clk);
        bus.s_valid_x = 1'b0;
        bus.s_valid_f = 1'b0;
        bus.m_ready_y = 1'b0;
        #1;
        chk("rearm_ready", 32'({bus.s_ready_x, bus.s_ready_f}), 3);
`ifdef CONV_PERF_CNT_EN
        chk("busy_cycles", 32'(busy_cycles), busy);
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
